// File: rtl/song_rom_bank_pkg.sv
// song_rom_bank_pkg: shared widths, entry type and the song ROM contents.
package song_rom_bank_pkg;
    localparam int NOTE_W  = 6;
    localparam int DUR_W   = 6;
    localparam int SONG_W  = 2;
    localparam int IDX_W   = 5;
    localparam int ADDR_W  = SONG_W + IDX_W;
    localparam int ENTRY_W = NOTE_W + DUR_W;
    localparam int DEPTH   = 1 << ADDR_W;

    typedef logic [ENTRY_W-1:0] entry_t;

    // Four songs of 32 slots each; index 31 of every song is always a zero rest.
    localparam entry_t SONG_TABLE [DEPTH] = '{
        12'h28C, 12'h2CC, 12'h30C, 12'h28C, 12'h30C, 12'h34C, 12'h398, 12'h28C,
        12'h2CC, 12'h30C, 12'h34C, 12'h38C, 12'h3D8, 12'h34C, 12'h30C, 12'h2CC,
        12'h28C, 12'h24C, 12'h20C, 12'h24C, 12'h28C, 12'h2CC, 12'h298, 12'h000,
        12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000,
        12'h3D0, 12'h390, 12'h350, 12'h310, 12'h350, 12'h390, 12'h3D0, 12'h3E0,
        12'h410, 12'h3D0, 12'h390, 12'h350, 12'h310, 12'h2D0, 12'h290, 12'h250,
        12'h290, 12'h2D0, 12'h310, 12'h350, 12'h390, 12'h3D0, 12'h410, 12'h450,
        12'h410, 12'h3D0, 12'h390, 12'h350, 12'h310, 12'h2D0, 12'h3E0, 12'h000,
        12'h1C6, 12'h1C6, 12'h206, 12'h246, 12'h206, 12'h1C6, 12'h186, 12'h146,
        12'h186, 12'h1C6, 12'h206, 12'h24C, 12'h1C6, 12'h186, 12'h146, 12'h10C,
        12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000,
        12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000,
        12'h454, 12'h414, 12'h3D4, 12'h394, 12'h3D4, 12'h414, 12'h454, 12'h4A8,
        12'h454, 12'h414, 12'h3D4, 12'h394, 12'h354, 12'h314, 12'h2D4, 12'h368,
        12'h394, 12'h3D4, 12'h414, 12'h454, 12'h000, 12'h000, 12'h000, 12'h000,
        12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000
    };
endpackage

// File: rtl/song_rom_bank_dffre.sv
// dffre: enabled register with asynchronous active-low clear.
module dffre #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             r,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge r)
        if (!r) q <= '0;
        else if (en) q <= d;
endmodule

// File: rtl/song_rom_bank.sv
// song_rom_bank: four-song note ROM with a registered, one-cycle read port.
module song_rom_bank
    import song_rom_bank_pkg::*;
#(
    parameter int NOTE_W = song_rom_bank_pkg::NOTE_W,
    parameter int DUR_W  = song_rom_bank_pkg::DUR_W,
    parameter int SONG_W = song_rom_bank_pkg::SONG_W,
    parameter int IDX_W  = song_rom_bank_pkg::IDX_W
) (
    input  logic              clk,
    input  logic              r,
    input  logic              en,
    input  logic [SONG_W-1:0] song,
    input  logic [IDX_W-1:0]  note_idx,
    output logic [NOTE_W-1:0] note,
    output logic [DUR_W-1:0]  duration,
    output logic              valid
);
    localparam int EW = NOTE_W + DUR_W;

    logic [SONG_W+IDX_W-1:0] addr;
    logic [EW-1:0]           entry_d;
    logic [EW-1:0]           entry_q;
    logic                    valid_q;

    // Song in the MSBs, so each song occupies one contiguous 32-entry page.
    assign addr    = {song, note_idx};
    assign entry_d = EW'(SONG_TABLE[addr]);

    dffre #(.WIDTH(EW)) u_entry (
        .clk (clk),
        .r   (r),
        .en  (en),
        .d   (entry_d),
        .q   (entry_q)
    );

    dffre #(.WIDTH(1)) u_valid (
        .clk (clk),
        .r   (r),
        .en  (1'b1),
        .d   (en),
        .q   (valid_q)
    );

    assign note     = entry_q[EW-1:DUR_W];
    assign duration = entry_q[DUR_W-1:0];
    assign valid    = valid_q;
endmodule

// File: tb/tb_song_rom_bank.sv
// tb_song_rom_bank: scoreboard bench for the song ROM read port.
module tb_song_rom_bank;
    import song_rom_bank_pkg::*;

    logic       clk = 1'b0;
    logic       r = 1'b0;
    logic       en = 1'b0;
    logic [1:0] song = '0;
    logic [4:0] note_idx = '0;
    logic [5:0] note;
    logic [5:0] duration;
    logic       valid;

    int n_cmp = 0;
    int n_bad = 0;
    logic [12:0] exp_q [$];
    logic [11:0] model = '0;
    logic [12:0] got, exp;

    song_rom_bank dut (
        .clk      (clk),
        .r        (r),
        .en       (en),
        .song     (song),
        .note_idx (note_idx),
        .note     (note),
        .duration (duration),
        .valid    (valid)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic e, input logic [6:0] a);
        en       = e;
        song     = a[6:5];
        note_idx = a[4:0];
        if (e) model = SONG_TABLE[a];
        exp_q.push_back({e, model});
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({valid, note, duration} !== 13'h0) begin
            n_bad++;
            $display("FAIL reset_initial got=%h want=0", {valid, note, duration});
        end
        en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({valid, note, duration} !== 13'h0) begin
                n_bad++;
                $display("FAIL reset_overrides_en got=%h want=0", {valid, note, duration});
            end
        end
        en = 1'b0;
        r  = 1'b1;
        model = '0;
    endtask

    task automatic test_first_read();
        drive(1'b1, 7'd0);
        @(negedge clk);
        exp = exp_q.pop_front();
        got = {valid, note, duration};
        n_cmp++;
        if (got !== exp || note !== 6'd10 || duration !== 6'd12 || valid !== 1'b1) begin
            n_bad++;
            $display("FAIL first_read got=%h want=%h (note 10 dur 12 valid 1)", got, exp);
        end
    endtask

    task automatic test_sweep();
        for (int a = 0; a < 128; a++) begin
            drive(1'b1, 7'(a));
            @(negedge clk);
            exp = exp_q.pop_front();
            got = {valid, note, duration};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL sweep addr=%0d got=%h want=%h", a, got, exp);
            end
            if (a % 32 == 31) begin
                n_cmp++;
                if (got !== 13'h1000) begin
                    n_bad++;
                    $display("FAIL song_end_rest addr=%0d got=%h want=1000", a, got);
                end
            end
        end
    endtask

    task automatic test_hold();
        drive(1'b1, 7'd32);
        @(negedge clk);
        exp = exp_q.pop_front();
        got = {valid, note, duration};
        n_cmp++;
        if (got !== exp || got !== 13'h13D0) begin
            n_bad++;
            $display("FAIL hold_setup got=%h want=13d0", got);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 7'd95);
            @(negedge clk);
            exp = exp_q.pop_front();
            got = {valid, note, duration};
            n_cmp++;
            if (got !== exp || got !== 13'h03D0) begin
                n_bad++;
                $display("FAIL hold cycle=%0d got=%h want=03d0", i, got);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0]  addrs [3] = '{7'd31, 7'd32, 7'd0};
        logic [11:0] wants [3] = '{12'h000, 12'h3D0, 12'h28C};
        drive(1'b1, addrs[0]);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i < 2) drive(1'b1, addrs[i+1]);
            else en = 1'b0;
            exp = exp_q.pop_front();
            got = {valid, note, duration};
            n_cmp++;
            if (got !== exp || got !== {1'b1, wants[i]}) begin
                n_bad++;
                $display("FAIL back_to_back addr=%0d got=%h want=%h", addrs[i], got, {1'b1, wants[i]});
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0] a;
        for (int i = 0; i < 4; i++) begin
            a = 7'(10 + i * 29);
            drive(1'b1, a);
            @(negedge clk);
            exp = exp_q.pop_front();
            got = {valid, note, duration};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL stream addr=%0d got=%h want=%h", a, got, exp);
            end
        end
        drive(1'b1, 7'd70);
        r = 1'b0;
        exp_q.delete();
        #1;
        n_cmp++;
        if ({valid, note, duration} !== 13'h0) begin
            n_bad++;
            $display("FAIL async_reset got=%h want=0", {valid, note, duration});
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({valid, note, duration} !== 13'h0) begin
                n_bad++;
                $display("FAIL reset_hold cycle=%0d got=%h want=0", i, {valid, note, duration});
            end
        end
        r = 1'b1;
        model = '0;
        drive(1'b1, 7'd96);
        @(negedge clk);
        exp = exp_q.pop_front();
        got = {valid, note, duration};
        n_cmp++;
        if (got !== exp || got !== 13'h1454) begin
            n_bad++;
            $display("FAIL post_reset_read got=%h want=1454", got);
        end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_first_read();
        test_sweep();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/song_rom_bank.md
SONG_ROM_BANK -- requirements
Module: song_rom_bank

Interface
REQ-001 Parameter NOTE_W, default 6: note-code width.
REQ-002 Parameter DUR_W, default 6: duration width.
REQ-003 Parameter SONG_W, default 2: song-select width, giving 4 songs.
REQ-004 Parameter IDX_W, default 5: note-index width, giving 32 notes per song.
REQ-005 Port clk, input, 1: single clock; all logic on the rising edge.
REQ-006 Port r, input, 1: reset, asynchronous and active-low.
REQ-007 Port en, input, 1: read enable.
REQ-008 Port song, input, SONG_W: song select.
REQ-009 Port note_idx, input, IDX_W: note index within the song.
REQ-010 Port note, output, NOTE_W: note code of the addressed entry.
REQ-011 Port duration, output, DUR_W: duration of the addressed entry.
REQ-012 Port valid, output, 1: note/duration hold a fresh read.

Function
REQ-013 Address = {song, note_idx} (7 bits, 128 entries), with song in the MSBs.
REQ-014 Each entry is 12 bits: [11:6] = note, [5:0] = duration.
REQ-015 Read is synchronous: on the rising edge with en=1, the entry at the sampled address is registered onto {note, duration}.
REQ-016 Read latency is exactly 1 cycle.
REQ-017 With en=0, {note, duration} and valid hold their previous values, whatever the address inputs do.
REQ-018 On each rising edge, valid <= en; valid is high for one cycle after each enabled read.
REQ-019 Entry 0 of each song: song0 = 12'h28C (note 10, duration 12), song1 = 12'h3D0, song2 = 12'h1C6, song3 = 12'h454.
REQ-020 A song shorter than 32 notes is padded to index 31 with 12'h000 (rest, duration 0).
REQ-021 Entries 31, 63, 95 and 127 are always 12'h000.
REQ-022 The address has no bounds check; note_idx 31 -> 0 is an ordinary address change, and song wraps naturally at 4 songs.
REQ-023 The block has no combinational path from inputs to outputs.

Reset
REQ-024 While r=0: note=0, duration=0, valid=0, applied immediately without waiting for a clock edge.
REQ-025 Reset asserted mid-read overrides en.
REQ-026 On the first enabled edge after r rises, a normal read occurs with no extra latency.

Structure
REQ-027 A shared package holds NOTE_W, DUR_W, SONG_W, IDX_W, the 12-bit entry type and the 128-entry SONG_TABLE constant.
REQ-028 The ROM array is initialised only from SONG_TABLE.
REQ-029 One sub-module, dffre:
- parameter WIDTH (default 1); ports clk, r, en, d[WIDTH], q[WIDTH];
- q <= d on the rising edge when en=1;
- q is cleared to 0 asynchronously while r=0.
REQ-030 Two dffre instances: WIDTH=12 as the ROM output register, and WIDTH=1 as the valid flag with en tied high.

Verification
REQ-031 r=0 asserted between clock edges -> note=0, duration=0, valid=0 immediately.
REQ-032 en=1, song=0, note_idx=0 -> one cycle later: note=10, duration=12, valid=1.
REQ-033 Read every address 0..127, one per cycle -> each output equals SONG_TABLE[addr] one cycle later, and entries 31/63/95/127 read 12'h000.
REQ-034 Read song=1, note_idx=0 (12'h3D0), then en=0 with the address changed to 95 for 5 cycles -> outputs stay 12'h3D0 and valid=0 after the first cycle.
REQ-035 Back-to-back reads at addresses 31, 32, 0 -> outputs 12'h000, 12'h3D0, 12'h28C on consecutive cycles.
REQ-036 r pulsed low during a stream of reads -> outputs 0 during reset, and the first enabled read after release returns correct data.
